// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: loads 16 words, streams W0..W79 and then the tail round slots.
// Optional macro SHA1_SCHED_BSWAP_EN byte-reverses each incoming word for little-endian sources.
module sha1_msg_schedule #(
    parameter int TAIL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] w_out,
    output logic [7:0]  round_out,
    output logic        round_valid,
    output logic        w_valid,
    input  logic        out_ready,
    output logic        block_done
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_TAIL   = 2'd2;
    localparam logic [7:0] LAST_ROUND = 8'(79 + TAIL_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [7:0]  round_q, round_d;
    logic [31:0] buf_q [16];
    logic [31:0] buf_d [16];
    logic [31:0] in_word_s;
    logic [31:0] w_exp;
    logic [3:0]  t4;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

`ifdef SHA1_SCHED_BSWAP_EN
    assign in_word_s = bswap32(in_word);
`else
    assign in_word_s = in_word;
`endif

    // The 16-entry buffer is used as a circular window over W[t-16..t-1].
    assign t4    = round_q[3:0];
    assign w_exp = rotl1(buf_q[t4 + 4'd13] ^ buf_q[t4 + 4'd8] ^ buf_q[t4 + 4'd2] ^ buf_q[t4]);

    always_comb begin
        in_ready    = (state_q == S_LOAD);
        round_valid = (state_q == S_EXPAND) || (state_q == S_TAIL);
        w_valid     = (state_q == S_EXPAND);
        round_out   = round_q;
        block_done  = (state_q == S_TAIL) && out_ready && (round_q == LAST_ROUND);
        w_out       = 32'd0;
        if (state_q == S_EXPAND) begin
            w_out = (round_q < 8'd16) ? buf_q[t4] : w_exp;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        round_d    = round_q;
        buf_d      = buf_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    buf_d[load_cnt_q] = in_word_s;
                    load_cnt_d        = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        load_cnt_d = 4'd0;
                        state_d    = S_EXPAND;
                        round_d    = 8'd0;
                    end
                end
            end
            S_EXPAND: begin
                if (out_ready) begin
                    if (round_q >= 8'd16) begin
                        buf_d[t4] = w_exp;
                    end
                    round_d = round_q + 8'd1;
                    if (round_q == 8'd79) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (out_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = S_LOAD;
                        round_d = 8'd0;
                    end else begin
                        round_d = round_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                round_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            load_cnt_q <= 4'd0;
            round_q    <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            round_q    <= round_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// Scoreboard bench for sha1_msg_schedule: reference schedule per block, compared round by round.
// Honours SHA1_SCHED_BSWAP_EN by presenting words byte-reversed.
module tb_sha1_msg_schedule;

    localparam int TAIL = 4;
    localparam int LAST = 79 + TAIL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] w_out;
    logic [7:0]  round_out;
    logic        round_valid;
    logic        w_valid;
    logic        out_ready;
    logic        block_done;

    sha1_msg_schedule #(.TAIL_CYCLES(TAIL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .w_out      (w_out),
        .round_out  (round_out),
        .round_valid(round_valid),
        .w_valid    (w_valid),
        .out_ready  (out_ready),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic [31:0] w;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] blk [16];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] to_input(input logic [31:0] x);
`ifdef SHA1_SCHED_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] spot_value(input int r);
        case (r)
            0:  return 32'h61626380;
            15: return 32'h00000018;
            16: return 32'hC2C4C700;
            17: return 32'h00000000;
            18: return 32'h00000030;
            19: return 32'h85898E01;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    // Reference expansion uses a flat 80-entry array and pushes every output slot.
    task automatic push_expected();
        logic [31:0] w [80];
        logic [31:0] x;
        exp_t e;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) w[t] = blk[t];
            else begin
                x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = {x[30:0], x[31]};
            end
            e.r = 8'(t);
            e.w = w[t];
            sbq.push_back(e);
        end
        for (int t = 80; t <= LAST; t++) begin
            e.r = 8'(t);
            e.w = 32'd0;
            sbq.push_back(e);
        end
    endtask

    task automatic send_block(input bit gaps);
        int i = 0;
        while (i < 16) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_word  = to_input(blk[i]);
                i++;
            end
        end
        push_expected();
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_word = 32'd0; out_ready = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (w_out !== 32'd0)      begin errors++; $display("FAIL reset_w_out got %h exp 0", w_out); end
        checks++; if (round_out !== 8'd0)   begin errors++; $display("FAIL reset_round_out got %0d exp 0", round_out); end
        checks++; if (round_valid !== 1'b0) begin errors++; $display("FAIL reset_round_valid got %b exp 0", round_valid); end
        checks++; if (w_valid !== 1'b0)     begin errors++; $display("FAIL reset_w_valid got %b exp 0", w_valid); end
        checks++; if (block_done !== 1'b0)  begin errors++; $display("FAIL reset_block_done got %b exp 0", block_done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abc(input string tag);
        int run = 0;
        int cyc = 0;
        int done_cnt = 0;
        exp_t e;
        set_abc();
        send_block(1'b0);
        while (sbq.size() > 0 && cyc < 400) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1 cyc++;
            e = sbq[0];
            if (round_valid === 1'b1) run++;
            if (block_done === 1'b1) done_cnt++;
            checks++;
            if (round_valid !== 1'b1 || round_out !== e.r || w_out !== e.w || w_valid !== (e.r < 8'd80)) begin
                errors++;
                $display("FAIL %s_round got r=%0d w=%h rv=%b wv=%b exp r=%0d w=%h", tag, round_out, w_out, round_valid, w_valid, e.r, e.w);
            end
            if (e.r <= 8'd19 && (e.r <= 8'd0 || e.r >= 8'd15)) begin
                checks++;
                if (w_out !== spot_value(int'(e.r))) begin
                    errors++;
                    $display("FAIL %s_spot r=%0d got %h exp %h", tag, e.r, w_out, spot_value(int'(e.r)));
                end
            end
            checks++;
            if (block_done !== (e.r == 8'(LAST))) begin
                errors++;
                $display("FAIL %s_block_done r=%0d got %b exp %b", tag, e.r, block_done, (e.r == 8'(LAST)));
            end
            void'(sbq.pop_front());
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL %s_timeout got %0d pending exp 0", tag, sbq.size()); sbq.delete(); end
        checks++; if (run != LAST + 1)  begin errors++; $display("FAIL %s_run_len got %0d exp %0d", tag, run, LAST + 1); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL %s_done_count got %0d exp 1", tag, done_cnt); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || round_valid !== 1'b0 || round_out !== 8'd0) begin
            errors++;
            $display("FAIL %s_after got in_ready=%b rv=%b r=%0d exp 1 0 0", tag, in_ready, round_valid, round_out);
        end
    endtask

    task automatic test_stall();
        int cyc = 0;
        int stall = 0;
        exp_t e;
        set_abc();
        send_block(1'b0);
        while (sbq.size() > 0 && cyc < 400) begin
            @(negedge clk);
            e = sbq[0];
            out_ready = !(e.r == 8'd16 && stall < 5);
            #1 cyc++;
            checks++;
            if (round_out !== e.r || w_out !== e.w || round_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_round got r=%0d w=%h exp r=%0d w=%h", round_out, w_out, e.r, e.w);
            end
            if (!out_ready) begin
                stall++;
                checks++;
                if (round_out !== 8'd16 || w_out !== 32'hC2C4C700 || block_done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold got r=%0d w=%h exp r=16 w=c2c4c700", round_out, w_out);
                end
            end else begin
                void'(sbq.pop_front());
            end
        end
        checks++; if (sbq.size() != 0 || stall != 5) begin
            errors++;
            $display("FAIL stall_timeout got pending=%0d stalls=%0d exp 0 5", sbq.size(), stall);
            sbq.delete();
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_expand_ignore();
        int cyc = 0;
        exp_t e;
        set_abc();
        send_block(1'b0);
        while (sbq.size() > 0 && cyc < 400) begin
            @(negedge clk);
            e = sbq[0];
            out_ready = 1'b1;
            in_valid  = (e.r >= 8'd2 && e.r <= 8'd20);
            in_word   = 32'hDEADBEEF;
            #1 cyc++;
            checks++;
            if (in_ready !== 1'b0 || round_out !== e.r || w_out !== e.w) begin
                errors++;
                $display("FAIL ignore_round got rdy=%b r=%0d w=%h exp rdy=0 r=%0d w=%h", in_ready, round_out, w_out, e.r, e.w);
            end
            void'(sbq.pop_front());
        end
        in_valid = 1'b0;
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL ignore_timeout got %0d pending exp 0", sbq.size()); sbq.delete(); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midblock();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_word  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || round_valid !== 1'b0 || w_out !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b rv=%b w=%h exp 1 0 0", in_ready, round_valid, w_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_abc("midreset");
    endtask

    task automatic test_back_to_back();
        int cyc;
        exp_t e;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            send_block(1'b1);
            cyc = 0;
            while (sbq.size() > 0 && cyc < 1000) begin
                @(negedge clk);
                e = sbq[0];
                out_ready = ($urandom_range(0, 3) != 0);
                #1 cyc++;
                checks++;
                if (round_out !== e.r || w_out !== e.w || w_valid !== (e.r < 8'd80) || in_ready !== 1'b0 ||
                    block_done !== (out_ready && e.r == 8'(LAST))) begin
                    errors++;
                    $display("FAIL b2b_round blk=%0d got r=%0d w=%h done=%b exp r=%0d w=%h", b, round_out, w_out, block_done, e.r, e.w);
                end
                if (out_ready) void'(sbq.pop_front());
            end
            checks++; if (sbq.size() != 0) begin errors++; $display("FAIL b2b_timeout got %0d pending exp 0", sbq.size()); sbq.delete(); end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_stall();
        test_expand_ignore();
        test_reset_midblock();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
